uart_rx: RTL and testbench

- UART receiver. It is the line-side consumer of the serial stream produced by the team's uart_tx.
- Frame format: 8N1, LSB first, idle-high line, matching uart_tx.
- It synchronises rx_i, detects the start edge, and samples each bit at mid-bit using a 3-sample majority vote.
- It presents each received byte on data_o with a one-cycle rx_done_o strobe, and flags bad stop bits on frame_err_o.

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line. Two-flop synchroniser, start-edge detect,
// 3-sample majority vote around mid-bit, one-cycle rx_done_o / frame_err_o strobes.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       rx_busy_o
);

  localparam int unsigned BIT_MAX = CLK_FREQ / BAUD_RATE - 1;
  localparam int unsigned HALF    = BIT_MAX / 2;
  localparam int unsigned CntW    = $clog2(BIT_MAX + 1);

  localparam logic [CntW-1:0] CntBitMax = CntW'(BIT_MAX);
  localparam logic [CntW-1:0] CntSamp0  = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntSamp1  = CntW'(HALF);
  localparam logic [CntW-1:0] CntVote   = CntW'(HALF + 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StStop, StDone, StWaitIdle
  } state_e;

  state_e            state_q, state_d;
  logic              sync_q, rx_s_q, rx_d_q;
  logic              samp0_q, samp0_d, samp1_q, samp1_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  logic fall, at_vote, at_end, vote;

  assign fall    = rx_d_q & ~rx_s_q;
  assign at_vote = (cnt_q == CntVote);
  assign at_end  = (cnt_q == CntBitMax);
  // The third sample is taken live from rx_s at the vote point.
  assign vote    = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (fall) state_d = StStart;
      StStart: begin
        if (at_vote && vote) state_d = StIdle;
        else if (at_end)     state_d = StData;
      end
      StData:     if (at_end && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:     if (at_vote) state_d = vote ? StDone : StWaitIdle;
      StDone:     state_d = StIdle;
      StWaitIdle: if (rx_s_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    samp0_d   = (cnt_q == CntSamp0) ? rx_s_q : samp0_q;
    samp1_d   = (cnt_q == CntSamp1) ? rx_s_q : samp1_q;
    rx_busy_o = (state_q != StIdle);
    case (state_q)
      StIdle: bit_idx_d = '0;
      StStart: cnt_d = at_end ? '0 : cnt_q + 1'b1;
      StData: begin
        cnt_d = at_end ? '0 : cnt_q + 1'b1;
        if (at_vote) shift_d[bit_idx_q] = vote;
        if (at_end && (bit_idx_q != 3'd7)) bit_idx_d = bit_idx_q + 3'd1;
      end
      StStop: begin
        cnt_d = at_end ? '0 : cnt_q + 1'b1;
        if (at_vote && !vote) ferr_d = 1'b1;
      end
      StDone: begin
        data_d = shift_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= rx_i;
      rx_s_q    <= sync_q;
      rx_d_q    <= rx_s_q;
      samp0_q   <= samp0_d;
      samp1_q   <= samp1_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial line driver plays the transmitter, a monitor collects strobes,
// and expected bytes/counts come from the frame contents the bench itself sends.
module tb_uart_rx;

  localparam int CLK_FREQ  = 10;
  localparam int BAUD_RATE = 1;
  localparam int BIT_MAX   = CLK_FREQ / BAUD_RATE - 1;
  localparam int HALF      = BIT_MAX / 2;
  localparam int BIT_CYC   = BIT_MAX + 1;
  localparam int EXP_LAT   = 2 + 9 * BIT_CYC + HALF + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       rx_done_o, frame_err_o, rx_busy_o;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         done_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .rx_done_o   (rx_done_o),
    .frame_err_o (frame_err_o),
    .rx_busy_o   (rx_busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        rxq.push_back(data_o);
      end
      if (frame_err_o) ferr_cnt++;
      if (rx_done_o && frame_err_o) both_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits of {stop, data, start}, one bit period each; optional 1-clk glitch.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits,
                            input int gbit, input int goff);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < BIT_CYC; j++) begin
        rx_i = (i == gbit && j == goff) ? ~fr[i] : fr[i];
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    check({tag, "_present"}, (rxq.size() > 0) ? 1 : 0, 1);
    if (rxq.size() > 0) begin
      got = rxq.pop_front();
      check(tag, int'(got), int'(exp));
    end
  endtask

  initial begin
    int d0, f0, lat;
    logic [7:0] b;

    // Reset and idle line
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", int'(data_o), 0);
    check("rst_done", int'(rx_done_o), 0);
    check("rst_ferr", int'(frame_err_o), 0);
    check("rst_busy", int'(rx_busy_o), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_bits(20);
    @(negedge clk);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_ferr_cnt", ferr_cnt, 0);
    check("idle_data", int'(data_o), 0);
    check("idle_busy", int'(rx_busy_o), 0);
    @(posedge clk); #1;

    // Single frame 0xA5 with latency
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 10, -1, 0);
    idle_bits(2);
    check("a5_pulses", done_cnt - d0, 1);
    expect_byte("a5_byte", 8'hA5);
    check("a5_data_hold", int'(data_o), 8'hA5);
    lat = done_cyc - fall_cyc;
    check("a5_latency_in_window", (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2) ? 1 : 0, 1);

    // Back-to-back frames, no gap
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1, 10, -1, 0);
    send_frame(8'hFF, 1'b1, 10, -1, 0);
    send_frame(8'h55, 1'b1, 10, -1, 0);
    idle_bits(2);
    check("b2b_pulses", done_cnt - d0, 3);
    check("b2b_ferr", ferr_cnt - f0, 0);
    expect_byte("b2b_00", 8'h00);
    expect_byte("b2b_ff", 8'hFF);
    expect_byte("b2b_55", 8'h55);

    // Short start pulse is a false start
    d0 = done_cnt; f0 = ferr_cnt;
    rx_i = 1'b0;
    repeat (BIT_MAX / 4) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (4) @(negedge clk);
    check("false_start_busy_hi", int'(rx_busy_o), 1);
    repeat (6) @(negedge clk);
    check("false_start_busy_lo", int'(rx_busy_o), 0);
    @(posedge clk); #1;
    idle_bits(2);
    check("false_start_no_done", done_cnt - d0, 0);
    check("false_start_no_ferr", ferr_cnt - f0, 0);
    check("false_start_data", int'(data_o), 8'h55);

    // Mid-bit glitch rejected by vote
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1, 10, 3, HALF);
    idle_bits(2);
    check("glitch_pulses", done_cnt - d0, 1);
    expect_byte("glitch_byte", 8'h3C);

    // Bad stop bit with line held low, then recovery
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 10, -1, 0);
    rx_i = 1'b0;
    repeat (3 * BIT_CYC) @(posedge clk);
    #1;
    idle_bits(2);
    check("ferr_pulses", ferr_cnt - f0, 1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_data_kept", int'(data_o), 8'h3C);
    send_frame(8'h81, 1'b1, 10, -1, 0);
    idle_bits(2);
    check("after_ferr_pulses", done_cnt - d0, 1);
    expect_byte("after_ferr_81", 8'h81);

    // Reset during data bit 4
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hC3, 1'b1, 5, -1, 0);
    rx_i = 1'b0;
    repeat (HALF + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    rx_i = 1'b1;
    #1;
    check("midrst_data", int'(data_o), 0);
    check("midrst_done", int'(rx_done_o), 0);
    check("midrst_ferr", int'(frame_err_o), 0);
    check("midrst_busy", int'(rx_busy_o), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_bits(2);
    check("midrst_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
    send_frame(8'h5A, 1'b1, 10, -1, 0);
    idle_bits(2);
    expect_byte("midrst_5a", 8'h5A);
    check("midrst_data_5a", int'(data_o), 8'h5A);

    // Random bytes with random 0..2 bit gaps
    d0 = done_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      expq.push_back(b);
      send_frame(b, 1'b1, 10, -1, 0);
      idle_bits(int'($urandom_range(0, 2)));
    end
    idle_bits(2);
    check("rand_pulses", done_cnt - d0, 10);
    check("rand_ferr", ferr_cnt - f0, 0);
    while (expq.size() > 0) expect_byte("rand_byte", expq.pop_front());

    check("never_done_and_ferr", both_cnt, 0);
    check("no_stray_bytes", rxq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
